// File: rtl/pwl_activation.sv
// Pipelined piecewise-linear activation with a runtime-programmable segment table.
// Define PWL_TANH_EN to honour in_mode (tanh path); otherwise every sample is sigmoid.
module pwl_activation #(
    parameter int DATA_W   = 32,
    parameter int SEGMENTS = 8,
    parameter int SAT_VAL  = 1874,
    parameter int SHIFT_W  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        cfg_we,
    input  logic [1:0]                  cfg_sel,
    input  logic [$clog2(SEGMENTS)-1:0] cfg_addr,
    input  logic [DATA_W-1:0]           cfg_wdata
);

    localparam int AW = $clog2(SEGMENTS);
    localparam logic [DATA_W-1:0] SAT     = DATA_W'(SAT_VAL);
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W:0]   SUM_MAX = {2'b00, {(DATA_W-1){1'b1}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Segment table
    logic [DATA_W-1:0]  bp_tab    [SEGMENTS];
    logic [SHIFT_W-1:0] shift_tab [SEGMENTS];
    logic [DATA_W-1:0]  off_tab   [SEGMENTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < SEGMENTS; k++) begin
                bp_tab[AW'(k)]    <= '1;
                shift_tab[AW'(k)] <= SHIFT_W'(2);
                off_tab[AW'(k)]   <= SAT >> 1;
            end
        end else if (cfg_we && (int'(cfg_addr) < SEGMENTS)) begin
            case (cfg_sel)
                2'd0:    bp_tab[cfg_addr]    <= cfg_wdata;
                2'd1:    shift_tab[cfg_addr] <= cfg_wdata[SHIFT_W-1:0];
                2'd2:    off_tab[cfg_addr]   <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // S1: magnitude and sign
    logic              s1_valid;
    logic              s1_sign;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] abs_x;

    always_comb begin
        abs_x = in_data;
        if (in_data[DATA_W-1]) begin
            abs_x = (in_data == NEG_MIN) ? POS_MAX : ('0 - in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_a     <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= in_data[DATA_W-1];
            s1_a     <= abs_x;
        end
    end

`ifdef PWL_TANH_EN
    logic s1_mode;
    logic s2_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_mode <= 1'b0;
            s2_mode <= 1'b0;
        end else if (en) begin
            s1_mode <= in_mode;
            s2_mode <= s1_mode;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = in_mode;
`endif

    // S2: first breakpoint above the magnitude wins; no hit means saturation
    logic              hit;
    logic [AW-1:0]     seg;
    logic              s2_valid;
    logic              s2_sign;
    logic              s2_sat;
    logic [DATA_W-1:0] s2_a;
    logic [SHIFT_W-1:0] s2_shift;
    logic [DATA_W-1:0] s2_off;

    always_comb begin
        hit = 1'b0;
        seg = '0;
        for (int unsigned k = 0; k < SEGMENTS; k++) begin
            if (!hit && (s1_a < bp_tab[AW'(k)])) begin
                hit = 1'b1;
                seg = AW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_a     <= '0;
            s2_shift <= '0;
            s2_off   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_sat   <= !hit;
            s2_a     <= s1_a;
            s2_shift <= shift_tab[seg];
            s2_off   <= off_tab[seg];
        end
    end

    // S3: linear segment, positive clamp, then sign folding
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] result;

    always_comb begin
        sum = {1'b0, s2_a >> s2_shift} + {1'b0, s2_off};
        if (s2_sat) begin
            y = SAT;
        end else if (sum > SUM_MAX) begin
            y = POS_MAX;
        end else begin
            y = sum[DATA_W-1:0];
        end

        result = y;
        if (s2_sign) begin
            result = (y > SAT) ? '0 : (SAT - y);
        end
`ifdef PWL_TANH_EN
        if (s2_mode) begin
            result = s2_sign ? ('0 - y) : y;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_pwl_activation.sv
// Scoreboard bench for pwl_activation: driver pushes expected results, monitor pops on output handshake.
module tb_pwl_activation;

    localparam int DATA_W   = 32;
    localparam int SEGMENTS = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_mode = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_sel = '0;
    logic [2:0]        cfg_addr = '0;
    logic [DATA_W-1:0] cfg_wdata = '0;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] sb[$];

    pwl_activation #(.DATA_W(DATA_W), .SEGMENTS(SEGMENTS), .SAT_VAL(1874), .SHIFT_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [DATA_W-1:0] x, input logic m, input logic [DATA_W-1:0] e,
                        output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = m;
        #1;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [2:0] addr, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_addr = addr;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Monitor: pop on handshake, check hold against queue head while stalled.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0d with empty scoreboard", out_data);
            end else if (out_ready) begin
                chk("out_data", out_data, sb.pop_front());
            end else begin
                chk("stall_hold", out_data, sb[0]);
            end
        end
    end

    int w;
    int bp_v[8]  = '{1996, 4055, 5578, 6978, 8323, 9644, 10954, 13558};
    int off_v[8] = '{937, 1186, 1435, 1610, 1720, 1786, 1822, 1844};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        reset = 1'b0;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        for (int unsigned k = 0; k < 8; k++) begin
            cfg_write(2'd0, 3'(k), bp_v[k]);
            cfg_write(2'd1, 3'(k), k + 2);
            cfg_write(2'd2, 3'(k), off_v[k]);
        end

        // Latency: accept edge E1, output valid after E3
        send(32'd0, 1'b0, 32'd937, w);
        chk("lat_e1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_e2", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_e3", {31'b0, out_valid}, 32'd1);

        // Back-to-back stream
        send(32'd0,     1'b0, 32'd937,  w);
        send(32'd1000,  1'b0, 32'd1187, w);
        send(32'd3000,  1'b0, 32'd1561, w);
        send(32'd20000, 1'b0, 32'd1874, w);
        send(-32'sd1000, 1'b0, 32'd687, w);
        send(32'h8000_0000, 1'b0, 32'd0, w);
`ifdef PWL_TANH_EN
        send(-32'sd1000, 1'b1, 32'hFFFF_FB5D, w);
        send(32'd1000,   1'b1, 32'd1187, w);
`else
        send(-32'sd1000, 1'b1, 32'd687, w);
        send(32'd1000,   1'b1, 32'd1187, w);
`endif
        repeat (5) @(posedge clk);
        #1;

        // Backpressure
        out_ready = 1'b0;
        fork
            begin
                repeat (9) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(32'd0,     1'b0, 32'd937,  w);
        send(32'd1000,  1'b0, 32'd1187, w);
        send(32'd3000,  1'b0, 32'd1561, w);
        send(32'd20000, 1'b0, 32'd1874, w);
        tests++;
        if (w < 5) begin
            fails++;
            $display("FAIL stall_in_ready: 4th sample waited %0d cycles, expected at least 5", w);
        end
        repeat (6) @(posedge clk);
        #1;

        // Config write landing with a sample's accept
        send(32'd0, 1'b0, 32'd937, w);
        send(32'd0, 1'b0, 32'd937, w);
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_addr = 3'd0; cfg_wdata = 32'd1000;
        send(32'd0, 1'b0, 32'd1000, w);
        cfg_write(2'd3, 3'd0, 32'd5);
        send(32'd0, 1'b0, 32'd1000, w);
        repeat (6) @(posedge clk);
        #1;

        // Reset with samples in flight
        send(32'd0,    1'b0, 32'd1000, w);
        send(32'd1000, 1'b0, 32'd1250, w);
        send(32'd3000, 1'b0, 32'd1561, w);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_flush_valid", {31'b0, out_valid}, 32'd0);
        sb.delete();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        send(32'd0, 1'b0, 32'd937, w);

        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
